// File: rtl/serial_frame_loader_if.sv
// Bus bundle between the serial frame feeder (master) and serial_frame_loader (slave).
interface serial_frame_loader_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic             clr_req;
  logic [WIDTH-1:0] I;
  logic             load;
  logic             clear;
  logic             err;
  logic             busy;

  modport master (
    output sin, sin_valid, frame_start, clr_req,
    input  I, load, clear, err, busy
  );

  modport slave (
    input  sin, sin_valid, frame_start, clr_req,
    output I, load, clear, err, busy
  );
endinterface

// File: rtl/serial_frame_loader.sv
// Deserializes an LSB-first, even-parity serial frame into a parallel word with
// a one-cycle load strobe, and turns a clear request into a registered clear strobe.
module serial_frame_loader #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  clear_n,
  serial_frame_loader_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_LOAD   = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_data;
  logic             r_load;
  logic             r_clear;
  logic             r_err;
  logic             r_busy;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_load_nxt;
  logic             w_err_nxt;
  logic             w_parity;

  // XOR of captured data bits and the incoming parity bit; 0 means a good frame.
  assign w_parity = (^r_sh) ^ bus.sin;

  // State and output registers; reset drops every output to 0 immediately.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_load  <= 1'b0;
      r_clear <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_load  <= w_load_nxt;
      r_clear <= bus.clr_req;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and next-output logic; clear request beats frame restart beats normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_data_nxt  = r_data;
    w_load_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (bus.clr_req) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_sh_nxt    = '0;
    end else if (bus.frame_start) begin
      w_state_nxt = ST_SHIFT;
      w_cnt_nxt   = '0;
      w_sh_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_SHIFT: begin
          if (bus.sin_valid) begin
            w_sh_nxt[r_cnt] = bus.sin;
            w_cnt_nxt       = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              w_state_nxt = ST_PARITY;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_PARITY: begin
          if (bus.sin_valid) begin
            if (!w_parity) begin
              w_state_nxt = ST_LOAD;
              w_data_nxt  = r_sh;
              w_load_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.I     = r_data;
  assign bus.load  = r_load;
  assign bus.clear = r_clear;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Self-checking bench for serial_frame_loader: directed frames plus randomized traffic
// compared cycle by cycle against a frame-level reference model.
module tb_serial_frame_loader;

  localparam int unsigned W = 4;

  logic clk;
  logic clear_n;

  serial_frame_loader_if #(.WIDTH(W)) bus ();

  serial_frame_loader #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: a frame is a list of received bits; it completes after W+1 bits.
  bit         m_active;
  bit         m_in_load;
  bit         m_bits[$];
  logic [W-1:0] exp_I;
  logic       exp_load;
  logic       exp_err;
  logic       exp_clear;
  logic       exp_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_in_load = 1'b0;
    m_bits.delete();
    exp_I     = '0;
    exp_load  = 1'b0;
    exp_err   = 1'b0;
    exp_clear = 1'b0;
    exp_busy  = 1'b0;
  endtask

  task automatic model_step();
    bit par;
    exp_load  = 1'b0;
    exp_err   = 1'b0;
    exp_clear = bus.clr_req;
    if (bus.clr_req) begin
      m_active  = 1'b0;
      m_in_load = 1'b0;
      m_bits.delete();
    end else if (bus.frame_start) begin
      m_active  = 1'b1;
      m_in_load = 1'b0;
      m_bits.delete();
    end else if (m_in_load) begin
      m_in_load = 1'b0;
    end else if (m_active && bus.sin_valid) begin
      m_bits.push_back(bus.sin);
      if (m_bits.size() == W + 1) begin
        par = 1'b0;
        foreach (m_bits[k]) par ^= m_bits[k];
        if (!par) begin
          for (int i = 0; i < W; i++) exp_I[i] = m_bits[i];
          exp_load  = 1'b1;
          m_in_load = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        m_active = 1'b0;
        m_bits.delete();
      end
    end
    exp_busy = m_active | m_in_load;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_load"},  32'(bus.load),  32'(exp_load));
    check_eq({tag, "_err"},   32'(bus.err),   32'(exp_err));
    check_eq({tag, "_clear"}, 32'(bus.clear), 32'(exp_clear));
    check_eq({tag, "_busy"},  32'(bus.busy),  32'(exp_busy));
    check_eq({tag, "_I"},     32'(bus.I),     32'(exp_I));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic fs, input logic sv, input logic s, input logic clr);
    bus.frame_start = fs;
    bus.sin_valid   = sv;
    bus.sin         = s;
    bus.clr_req     = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic p, input int stall_after,
                            input int stalls, input logic clr_on_par);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, 1'b1, w[i], 1'b0);
      if (i == stall_after)
        for (int j = 0; j < stalls; j++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    cyc(1'b0, 1'b1, p, clr_on_par);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    clear_n         = 1'b0;
    bus.frame_start = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.sin         = 1'b0;
    bus.clr_req     = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset");
    clear_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Good frame 0101, then I holds
    send_frame(4'b0101, 1'b0, -1, 0, 1'b0);
    check_eq("good_load", 32'(bus.load), 32'd1);
    check_eq("good_I",    32'(bus.I),    32'h5);
    check_eq("good_err",  32'(bus.err),  32'd0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_I",    32'(bus.I),    32'h5);
    check_eq("hold_load", 32'(bus.load), 32'd0);

    // Bad parity frame 1001
    send_frame(4'b1001, 1'b1, -1, 0, 1'b0);
    check_eq("bad_err",  32'(bus.err),  32'd1);
    check_eq("bad_load", 32'(bus.load), 32'd0);
    check_eq("bad_I",    32'(bus.I),    32'h5);
    check_eq("bad_busy", 32'(bus.busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("bad_err_pulse", 32'(bus.err), 32'd0);

    // Frame 1011 with a 3-cycle stall after bit 1
    send_frame(4'b1011, 1'b1, 1, 3, 1'b0);
    check_eq("stall_load", 32'(bus.load), 32'd1);
    check_eq("stall_I",    32'(bus.I),    32'hB);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Aborted frame then full frame 0011
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(4'b0011, 1'b0, -1, 0, 1'b0);
    check_eq("abort_load", 32'(bus.load), 32'd1);
    check_eq("abort_I",    32'(bus.I),    32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear request on the parity edge of a good frame
    send_frame(4'b0110, 1'b0, -1, 0, 1'b1);
    check_eq("clr_clear", 32'(bus.clear), 32'd1);
    check_eq("clr_load",  32'(bus.load),  32'd0);
    check_eq("clr_I",     32'(bus.I),     32'h3);
    check_eq("clr_busy",  32'(bus.busy),  32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("clr_pulse", 32'(bus.clear), 32'd0);

    // Async reset in the middle of a frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (6) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("stray_busy", 32'(bus.busy), 32'd0);
    check_eq("stray_load", 32'(bus.load), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 11) == 0),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
